// File: rtl/pulse_gen_pkg.sv
// Shared types and constants for the multi-channel pulse generator.
package pulse_gen_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    SHOT = 2'd2
  } state_e;

  typedef enum logic {
    CONT    = 1'b0,
    ONESHOT = 1'b1
  } mode_e;

  localparam logic MODE_CONT    = 1'b0;
  localparam logic MODE_ONESHOT = 1'b1;

endpackage

// File: rtl/pulse_gen_chan.sv
// One pulse channel: continuous PWM-style pulse or one-shot of W cycles.
// Optional PULSE_GEN_MULTI_SYNC_EN adds sync_i (phase realign / shot abort).
//
// state | meaning
// IDLE  | disabled, or one-shot armed waiting for trigger
// RUN   | continuous: phase counter cycles 0..P-1, pulse high on phases 0..W-1
// SHOT  | one-shot in progress: pulse and busy high for W cycles
module pulse_gen_chan
  import pulse_gen_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_i,
  input  logic             mode_i,
  input  logic [CNT_W-1:0] period_i,
  input  logic [CNT_W-1:0] width_i,
  input  logic             trig_i,
`ifdef PULSE_GEN_MULTI_SYNC_EN
  input  logic             sync_i,
`endif
  output logic             pulse_o,
  output logic             busy_o
);

  state_e           state_q, state_d;
  mode_e            mode_q, mode_d;
  logic [CNT_W-1:0] per_q, per_d, wid_q, wid_d, cnt_q, cnt_d;
  logic             pulse_q, pulse_d, busy_q, busy_d, en_q;
  logic [CNT_W-1:0] cnt_inc, per_last, wid_last;

  assign cnt_inc  = cnt_q + CNT_W'(1);
  // A zero period behaves as a period of one cycle.
  assign per_last = (per_q == '0) ? '0 : per_q - CNT_W'(1);
  assign wid_last = wid_q - CNT_W'(1);

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    per_d   = per_q;
    wid_d   = wid_q;
    cnt_d   = cnt_q;
    pulse_d = pulse_q;
    busy_d  = busy_q;
    if (!en_i) begin
      state_d = IDLE;
      cnt_d   = '0;
      pulse_d = 1'b0;
      busy_d  = 1'b0;
    end else if (!en_q) begin
      mode_d = mode_e'(mode_i);
      per_d  = period_i;
      wid_d  = width_i;
      cnt_d  = '0;
      busy_d = 1'b0;
      if (mode_i == MODE_ONESHOT) begin
        state_d = IDLE;
        pulse_d = 1'b0;
      end else begin
        state_d = RUN;
        pulse_d = (width_i != '0);
      end
`ifdef PULSE_GEN_MULTI_SYNC_EN
    end else if (sync_i) begin
      cnt_d  = '0;
      busy_d = 1'b0;
      if (state_q == RUN) begin
        pulse_d = (wid_q != '0);
      end else begin
        state_d = IDLE;
        pulse_d = 1'b0;
      end
`endif
    end else begin
      case (state_q)
        RUN: begin
          if (cnt_q == per_last) begin
            // Last cycle of the period: pick up the new period/width here.
            per_d   = period_i;
            wid_d   = width_i;
            cnt_d   = '0;
            pulse_d = (width_i != '0);
          end else begin
            cnt_d   = cnt_inc;
            pulse_d = (wid_q > cnt_inc);
          end
        end
        SHOT: begin
          if (cnt_q == wid_last) begin
            state_d = IDLE;
            cnt_d   = '0;
            pulse_d = 1'b0;
            busy_d  = 1'b0;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        IDLE: begin
          if (trig_i && (wid_q != '0) && (mode_q == ONESHOT)) begin
            state_d = SHOT;
            cnt_d   = '0;
            pulse_d = 1'b1;
            busy_d  = 1'b1;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
          pulse_d = 1'b0;
          busy_d  = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      mode_q  <= CONT;
      per_q   <= '0;
      wid_q   <= '0;
      cnt_q   <= '0;
      pulse_q <= 1'b0;
      busy_q  <= 1'b0;
      en_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      per_q   <= per_d;
      wid_q   <= wid_d;
      cnt_q   <= cnt_d;
      pulse_q <= pulse_d;
      busy_q  <= busy_d;
      en_q    <= en_i;
    end
  end

  assign pulse_o = pulse_q;
  assign busy_o  = busy_q;

endmodule

// File: rtl/pulse_gen_multi.sv
// NUM_CH independent pulse channels sharing one clock and reset.
// Optional PULSE_GEN_MULTI_SYNC_EN adds sync_start, broadcast to all channels.
module pulse_gen_multi
  import pulse_gen_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_CH-1:0]       ch_en,
  input  logic [NUM_CH-1:0]       cfg_mode,
  input  logic [NUM_CH*CNT_W-1:0] cfg_period,
  input  logic [NUM_CH*CNT_W-1:0] cfg_width,
  input  logic [NUM_CH-1:0]       trigger,
`ifdef PULSE_GEN_MULTI_SYNC_EN
  input  logic                    sync_start,
`endif
  output logic [NUM_CH-1:0]       pulse,
  output logic [NUM_CH-1:0]       busy
);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    pulse_gen_chan #(
      .CNT_W(CNT_W)
    ) u_chan (
      .clk     (clk),
      .rst_n   (rst_n),
      .en_i    (ch_en[i]),
      .mode_i  (cfg_mode[i]),
      .period_i(cfg_period[i*CNT_W +: CNT_W]),
      .width_i (cfg_width[i*CNT_W +: CNT_W]),
      .trig_i  (trigger[i]),
`ifdef PULSE_GEN_MULTI_SYNC_EN
      .sync_i  (sync_start),
`endif
      .pulse_o (pulse[i]),
      .busy_o  (busy[i])
    );
  end

endmodule

// File: tb/tb_pulse_gen_multi.sv
// Scoreboard bench for pulse_gen_multi: expected {busy,pulse} queued per cycle.
module tb_pulse_gen_multi;

  localparam int NC = 4;
  localparam int CW = 16;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NC-1:0]     ch_en, cfg_mode, trigger, pulse, busy;
  logic [NC*CW-1:0]  cfg_period, cfg_width;
`ifdef PULSE_GEN_MULTI_SYNC_EN
  logic              sync_start;
`endif

  int checks = 0;
  int errors = 0;
  logic [2*NC-1:0] exp_q[$];

  typedef struct {
    logic en; logic mode; int p; int w; logic trig; logic ep; logic eb;
  } step_t;

  always #5 clk = ~clk;

  pulse_gen_multi #(.NUM_CH(NC), .CNT_W(CW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ch_en     (ch_en),
    .cfg_mode  (cfg_mode),
    .cfg_period(cfg_period),
    .cfg_width (cfg_width),
    .trigger   (trigger),
`ifdef PULSE_GEN_MULTI_SYNC_EN
    .sync_start(sync_start),
`endif
    .pulse     (pulse),
    .busy      (busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ch(input int c, input logic m, input int p, input int w);
    cfg_mode[c] = m;
    cfg_period[c*CW +: CW] = CW'(p);
    cfg_width[c*CW +: CW]  = CW'(w);
  endtask

  function automatic step_t mk(input logic en, input logic mode, input int p, input int w,
                               input logic trig, input logic ep, input logic eb);
    step_t s;
    s.en = en; s.mode = mode; s.p = p; s.w = w; s.trig = trig; s.ep = ep; s.eb = eb;
    return s;
  endfunction

  task automatic test_reset();
    logic [7:0] e;
    rst_n = 1'b0; ch_en = '0; cfg_mode = '0; trigger = '0; cfg_period = '0; cfg_width = '0;
`ifdef PULSE_GEN_MULTI_SYNC_EN
    sync_start = 1'b0;
`endif
    set_ch(0, 1'b0, 5, 2);
    ch_en[0] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) begin
        ch_en = '0;
        @(negedge clk);
        rst_n = 1'b1;
      end
      exp_q.push_back('0);
      tick();
      e = exp_q.pop_front();
      checks++;
      if ({busy, pulse} !== e) begin
        errors++;
        $display("FAIL reset cyc %0d: got busy/pulse=%b expected %b", i, {busy, pulse}, e);
      end
    end
  endtask

  task automatic test_continuous();
    logic [7:0] e;
    logic s;
    set_ch(0, 1'b0, 5, 2);
    ch_en[0] = 1'b1;
    for (int i = 0; i < 35; i++) begin
      if (i < 15)      s = (i % 5) < 2;
      else if (i < 18) s = (i - 15) < 2;
      else if (i < 20) s = 1'b0;
      else if (i < 29) s = ((i - 20) % 3) == 0;
      else if (i < 34) s = 1'b1;
      else             s = 1'b0;
      exp_q.push_back({7'b0, s});
      tick();
      e = exp_q.pop_front();
      checks++;
      if ({busy, pulse} !== e) begin
        errors++;
        $display("FAIL continuous cyc %0d: got busy/pulse=%b expected %b", i, {busy, pulse}, e);
      end
      if (i == 17) set_ch(0, 1'b0, 3, 1);
      if (i == 28) set_ch(0, 1'b0, 0, 1);
      if (i == 33) ch_en[0] = 1'b0;
    end
  endtask

  task automatic test_edges();
    step_t t[$];
    logic [7:0] e;
    repeat (10) t.push_back(mk(1, 0, 5, 7, 0, 1, 0));
    t.push_back(mk(0, 0, 5, 7, 0, 0, 0));
    for (int k = 0; k < 6; k++) t.push_back(mk(1, 0, 5, 0, k[0], 0, 0));
    t.push_back(mk(0, 0, 5, 0, 0, 0, 0));
    repeat (5) t.push_back(mk(1, 1, 5, 0, 1, 0, 0));
    t.push_back(mk(0, 1, 5, 0, 0, 0, 0));
    foreach (t[k]) begin
      ch_en[0] = t[k].en;
      set_ch(0, t[k].mode, t[k].p, t[k].w);
      trigger[0] = t[k].trig;
      exp_q.push_back({3'b0, t[k].eb, 3'b0, t[k].ep});
      tick();
      e = exp_q.pop_front();
      checks++;
      if ({busy, pulse} !== e) begin
        errors++;
        $display("FAIL edges step %0d: got busy/pulse=%b expected %b", k, {busy, pulse}, e);
      end
    end
  endtask

  task automatic test_oneshot();
    step_t t[$];
    logic [7:0] e;
    t.push_back(mk(1, 1, 5, 4, 0, 0, 0));
    t.push_back(mk(1, 1, 5, 4, 1, 1, 1));
    t.push_back(mk(1, 1, 5, 4, 0, 1, 1));
    t.push_back(mk(1, 1, 5, 4, 1, 1, 1));
    t.push_back(mk(1, 1, 5, 4, 0, 1, 1));
    repeat (2) t.push_back(mk(1, 1, 5, 4, 0, 0, 0));
    t.push_back(mk(1, 1, 5, 4, 1, 1, 1));
    repeat (3) t.push_back(mk(1, 1, 5, 4, 0, 1, 1));
    t.push_back(mk(1, 1, 5, 4, 1, 0, 0));
    t.push_back(mk(1, 1, 5, 4, 0, 0, 0));
    repeat (2) t.push_back(mk(1, 0, 5, 4, 0, 0, 0));
    t.push_back(mk(1, 0, 5, 4, 1, 1, 1));
    repeat (3) t.push_back(mk(1, 0, 5, 4, 0, 1, 1));
    t.push_back(mk(1, 0, 5, 4, 0, 0, 0));
    t.push_back(mk(0, 1, 5, 4, 0, 0, 0));
    foreach (t[k]) begin
      ch_en[0] = t[k].en;
      set_ch(0, t[k].mode, t[k].p, t[k].w);
      trigger[0] = t[k].trig;
      exp_q.push_back({3'b0, t[k].eb, 3'b0, t[k].ep});
      tick();
      e = exp_q.pop_front();
      checks++;
      if ({busy, pulse} !== e) begin
        errors++;
        $display("FAIL oneshot step %0d: got busy/pulse=%b expected %b", k, {busy, pulse}, e);
      end
    end
  endtask

  task automatic test_independent();
    logic [7:0] e;
    logic [3:0] ep;
    set_ch(0, 1'b0, 5, 2);
    set_ch(1, 1'b0, 3, 1);
    set_ch(2, 1'b0, 2, 5);
    set_ch(3, 1'b0, 4, 3);
    ch_en = 4'hF;
    for (int i = 0; i < 25; i++) begin
      ep[0] = (i < 24) && ((i % 5) < 2);
      ep[1] = (i <= 10) && ((i % 3) == 0);
      ep[2] = (i < 24);
      ep[3] = (i < 24) && ((i % 4) < 3);
      exp_q.push_back({4'b0, ep});
      tick();
      e = exp_q.pop_front();
      checks++;
      if ({busy, pulse} !== e) begin
        errors++;
        $display("FAIL independent cyc %0d: got busy/pulse=%b expected %b", i, {busy, pulse}, e);
      end
      if (i == 10) ch_en[1] = 1'b0;
      if (i == 23) ch_en = '0;
    end
  endtask

  task automatic test_reset_mid_shot();
    logic [7:0] e;
    logic [3:0] ep [7] = '{4'b0010, 4'b0001, 4'b0001, 4'b0011, 4'b0001, 4'b0000, 4'b0010};
    logic [3:0] eb [7] = '{4'b0000, 4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0000, 4'b0000};
    logic       trg [7] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    set_ch(0, 1'b1, 5, 4);
    set_ch(1, 1'b0, 3, 1);
    ch_en = 4'b0011;
    for (int k = 0; k < 3; k++) begin
      trigger[0] = trg[k];
      exp_q.push_back({eb[k], ep[k]});
      tick();
      e = exp_q.pop_front();
      checks++;
      if ({busy, pulse} !== e) begin
        errors++;
        $display("FAIL pre_reset step %0d: got busy/pulse=%b expected %b", k, {busy, pulse}, e);
      end
    end
    trigger[0] = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    exp_q.push_back('0);
    e = exp_q.pop_front();
    checks++;
    if ({busy, pulse} !== e) begin
      errors++;
      $display("FAIL async_reset: got busy/pulse=%b expected %b", {busy, pulse}, e);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 7; k++) begin
      trigger[0] = trg[k];
      exp_q.push_back({eb[k], ep[k]});
      tick();
      e = exp_q.pop_front();
      checks++;
      if ({busy, pulse} !== e) begin
        errors++;
        $display("FAIL post_reset step %0d: got busy/pulse=%b expected %b", k, {busy, pulse}, e);
      end
    end
    ch_en = '0;
    tick();
  endtask

`ifdef PULSE_GEN_MULTI_SYNC_EN
  task automatic test_sync();
    logic [7:0] e;
    logic [3:0] ep;
    logic       trg [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    logic       syn [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    logic       exo [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    for (int k = 0; k < NC; k++) set_ch(k, 1'b0, 5 + k, 1);
    ch_en = '0;
    for (int i = 0; i < 21; i++) begin
      if (i < NC) ch_en[i] = 1'b1;
      sync_start = (i == 10);
      for (int k = 0; k < NC; k++) begin
        if (i < 10) ep[k] = (i >= k) && (((i - k) % (5 + k)) == 0);
        else        ep[k] = ((i - 10) % (5 + k)) == 0;
      end
      exp_q.push_back({4'b0, ep});
      tick();
      e = exp_q.pop_front();
      checks++;
      if ({busy, pulse} !== e) begin
        errors++;
        $display("FAIL sync cyc %0d: got busy/pulse=%b expected %b", i, {busy, pulse}, e);
      end
    end
    sync_start = 1'b0;
    ch_en = '0;
    tick();
    set_ch(0, 1'b1, 5, 4);
    ch_en[0] = 1'b1;
    for (int k = 0; k < 5; k++) begin
      trigger[0] = trg[k];
      sync_start = syn[k];
      exp_q.push_back({3'b0, exo[k], 3'b0, exo[k]});
      tick();
      e = exp_q.pop_front();
      checks++;
      if ({busy, pulse} !== e) begin
        errors++;
        $display("FAIL sync_abort step %0d: got busy/pulse=%b expected %b", k, {busy, pulse}, e);
      end
    end
    trigger = '0;
    sync_start = 1'b0;
    ch_en = '0;
    tick();
  endtask
`endif

  initial begin
    test_reset();
    test_continuous();
    test_edges();
    test_oneshot();
    test_independent();
    test_reset_mid_shot();
`ifdef PULSE_GEN_MULTI_SYNC_EN
    test_sync();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pulse_gen_multi.md
PULSE_GEN_MULTI -- requirements
Module: pulse_gen_multi

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, number of independent pulse channels (1..32).
REQ-002 SHALL have parameter CNT_W, default 16, width of the per-channel period and width counters (2..32).
REQ-003 SHALL have port clk, input, 1, the single clock for the whole block.
REQ-004 SHALL have port rst_n, input, 1, reset; asynchronous, active-low.
REQ-005 SHALL have port ch_en, input, NUM_CH, per-channel enable.
REQ-006 SHALL have port cfg_mode, input, NUM_CH, per-channel mode: 0 = continuous, 1 = one-shot.
REQ-007 SHALL have port cfg_period, input, NUM_CH x CNT_W, period in cycles.
REQ-008 SHALL have port cfg_width, input, NUM_CH x CNT_W, high time in cycles.
REQ-009 SHALL have port trigger, input, NUM_CH, one-shot start request.
REQ-010 SHALL have port pulse, output, NUM_CH, registered pulse outputs.
REQ-011 SHALL have port busy, output, NUM_CH, registered; high while a one-shot is in progress.

Function
REQ-012 Each channel SHALL have three states: IDLE, RUN (continuous) and SHOT (one-shot).
REQ-013 Each channel SHALL hold shadow registers for mode, period P and width W.
REQ-014 Shadow values SHALL load when ch_en goes 0->1; in RUN they SHALL also reload on the last cycle of every period.
REQ-015 Effective period SHALL be max(P,1); cfg_period = 0 behaves as 1.
REQ-016 Continuous mode, ch_en rising at edge N: the channel SHALL enter RUN, phase counter = 0, and pulse SHALL equal (W > 0) from N+1.
REQ-017 In RUN, the phase counter SHALL advance 0..P-1 and wrap to 0.
REQ-018 In RUN, pulse SHALL be high exactly on phase cycles 0..W-1 of every period.
REQ-019 W >= P SHALL give a constant-high pulse; W = 0 SHALL give a constant-low pulse; there SHALL be no glitch at the wrap.
REQ-020 One-shot mode: ch_en rising SHALL enter IDLE with pulse = 0 and busy = 0.
REQ-021 In IDLE, trigger = 1 with W > 0 SHALL enter SHOT.
REQ-022 In SHOT, pulse and busy SHALL be high for exactly W cycles, starting on the next cycle; the channel SHALL then return to IDLE.
REQ-023 Trigger while busy = 1 (including the final SHOT cycle) SHALL be ignored; trigger with W = 0 SHALL be ignored.
REQ-024 In continuous mode, busy SHALL stay 0.
REQ-025 ch_en = 0 SHALL force the channel to IDLE, with the counter, pulse and busy all 0 on the next edge, whatever the current state.
REQ-026 cfg_mode changes while enabled SHALL be ignored until the next ch_en rise.
REQ-027 All counter arithmetic SHALL be CNT_W bits with no overflow; the counter never exceeds P-1.
REQ-028 Channels SHALL be fully independent; NUM_CH = 1 SHALL be legal.

Reset
REQ-029 While rst_n = 0: all channels SHALL be IDLE; counters, shadow registers, pulse and busy SHALL be 0.
REQ-030 After rst_n deasserts, a channel with ch_en already high SHALL treat the first sampled cycle as a ch_en rise.
REQ-031 Reset asserted mid-period or mid-shot SHALL clear the channel immediately (asynchronously), with no residual pulse.

Configuration
REQ-032 Macro PULSE_GEN_MULTI_SYNC_EN, when defined, SHALL add input sync_start (1 bit).
REQ-033 With the macro, sync_start = 1 SHALL reset the phase counter of every channel in RUN to 0 on the same edge, so pulse = (W > 0) on the next cycle for all of them.
REQ-034 With the macro, sync_start SHALL abort any SHOT (pulse and busy drop next cycle, state IDLE) and SHALL have priority over trigger.
REQ-035 Without the macro, the sync_start port and its logic SHALL be absent; behaviour SHALL otherwise be identical.

Structure
REQ-036 Package pulse_gen_pkg SHALL hold: a state enum (IDLE, RUN, SHOT); a mode enum (CONT, ONESHOT); constants MODE_CONT = 0 and MODE_ONESHOT = 1.
REQ-037 Sub-module pulse_gen_chan SHALL implement one channel; pulse_gen_multi SHALL instantiate NUM_CH copies via generate.

Verification
REQ-038 Continuous, P = 5, W = 2, enable: pulse pattern SHALL be 11000 repeating from the cycle after enable.
REQ-039 Mid-run, write P = 3, W = 1 on phase 2: the old 11000 period SHALL complete, then 100 SHALL repeat; P = 0 SHALL behave as 1 (constant high when W >= 1).
REQ-040 One-shot, W = 4, trigger 1 cycle, second trigger 2 cycles later: exactly 4 cycles high, busy matching; the second trigger SHALL be ignored.
REQ-041 Edge cases: W = 0 -> pulse never high, trigger ignored; W = 7 with P = 5 -> constant high; ch_en dropped mid-pulse -> pulse 0 on the next edge.
REQ-042 Assert rst_n low mid-shot, then release with ch_en high: outputs 0 immediately; the channel SHALL restart cleanly per REQ-030.
REQ-043 Under PULSE_GEN_MULTI_SYNC_EN, four channels running with different phases, sync_start pulsed: all pulses SHALL realign to phase 0 on the next cycle.
